// File: rtl/sram_ctrl_if.sv
// Request/acknowledge bus between the system side and the SRAM controller.
// The master drives the request, the controller (slave) returns data and status.
interface sram_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int BANKS  = 2
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [2*BANKS-1:0]    be;
    logic [16*BANKS-1:0]   wdata;
    logic [16*BANKS-1:0]   rdata;
    logic                  ack;
    logic                  busy;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/sram_ctrl.sv
// Controller for banks of asynchronous 16-bit SRAM chips. Every pin-side
// output is a flop, so strobes are glitch-free. An access runs
// SETUP -> STROBE (WAIT_CYCLES+1) -> END (ack) -> TURN (TURN_CYCLES) -> IDLE.
// A request with no byte enables skips the SRAM entirely: IDLE -> END -> IDLE.
module sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int BANKS       = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sram_ctrl_if.slave            bus,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic [16*BANKS-1:0]   ram_data_read,
    output logic [16*BANKS-1:0]   ram_data_write,
    output logic                  ram_data_is_output,
    output logic [BANKS-1:0]      ram_ce_n,
    output logic [BANKS-1:0]      ram_ub_n,
    output logic [BANKS-1:0]      ram_lb_n,
    output logic                  ram_we_n,
    output logic                  ram_oe_n
);
    localparam int         BEW       = 2 * BANKS;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [3:0] TURN_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;
    localparam bit         HAS_TURN  = (TURN_CYCLES > 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_END    = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic            we_r;
    logic [BEW-1:0]  be_r;
    logic            nop_r;

    // A chip is selected when either of its byte lanes is enabled.
    function automatic logic [BANKS-1:0] chip_sel_n(input logic [BEW-1:0] be);
        logic [BANKS-1:0] sel_n;
        for (int i = 0; i < BANKS; i++) begin
            sel_n[i] = ~(be[2*i] | be[2*i+1]);
        end
        return sel_n;
    endfunction

    // Active-low byte lane strobe per chip; hi selects the upper byte.
    function automatic logic [BANKS-1:0] lane_n(input logic [BEW-1:0] be, input logic hi);
        logic [BANKS-1:0] l_n;
        for (int i = 0; i < BANKS; i++) begin
            l_n[i] = hi ? ~be[2*i+1] : ~be[2*i];
        end
        return l_n;
    endfunction

    // Access sequencer; every output is loaded with the value of the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r            <= ST_IDLE;
            cnt_r              <= 4'd0;
            we_r               <= 1'b0;
            be_r               <= '0;
            nop_r              <= 1'b0;
            bus.rdata          <= '0;
            bus.ack            <= 1'b0;
            bus.busy           <= 1'b0;
            ram_addr           <= '0;
            ram_data_write     <= '0;
            ram_data_is_output <= 1'b0;
            ram_ce_n           <= '1;
            ram_ub_n           <= '1;
            ram_lb_n           <= '1;
            ram_we_n           <= 1'b1;
            ram_oe_n           <= 1'b1;
        end else begin
            bus.ack <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req) begin
                        we_r     <= bus.we;
                        be_r     <= bus.be;
                        bus.busy <= 1'b1;
                        if (bus.be != '0) begin
                            state_r            <= ST_SETUP;
                            nop_r              <= 1'b0;
                            ram_addr           <= bus.addr;
                            ram_ce_n           <= chip_sel_n(bus.be);
                            ram_lb_n           <= lane_n(bus.be, 1'b0);
                            ram_ub_n           <= lane_n(bus.be, 1'b1);
                            ram_data_is_output <= bus.we;
                            if (bus.we) begin
                                ram_data_write <= bus.wdata;
                            end else begin
                                ram_data_write <= ram_data_write;
                            end
                        end else begin
                            // Nothing to transfer: acknowledge without touching the pins.
                            state_r <= ST_END;
                            nop_r   <= 1'b1;
                            bus.ack <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_STROBE;
                    cnt_r   <= WAIT_LOAD;
                    if (we_r) begin
                        ram_we_n <= 1'b0;
                    end else begin
                        ram_oe_n <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (cnt_r == 4'd0) begin
                        state_r  <= ST_END;
                        ram_we_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        bus.ack  <= 1'b1;
                        if (!we_r) begin
                            for (int k = 0; k < BEW; k++) begin
                                if (be_r[k]) begin
                                    bus.rdata[8*k +: 8] <= ram_data_read[8*k +: 8];
                                end
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_END: begin
                    // Deselect and release the data bus whichever way we leave END.
                    ram_ce_n           <= '1;
                    ram_ub_n           <= '1;
                    ram_lb_n           <= '1;
                    ram_data_is_output <= 1'b0;
                    if (nop_r || !HAS_TURN) begin
                        state_r  <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state_r <= ST_TURN;
                        cnt_r   <= TURN_LOAD;
                    end
                end
                ST_TURN: begin
                    if (cnt_r == 4'd0) begin
                        state_r  <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r            <= ST_IDLE;
                    bus.busy           <= 1'b0;
                    ram_ce_n           <= '1;
                    ram_ub_n           <= '1;
                    ram_lb_n           <= '1;
                    ram_we_n           <= 1'b1;
                    ram_oe_n           <= 1'b1;
                    ram_data_is_output <= 1'b0;
                end
            endcase
        end
    end
endmodule
